// File: rtl/gpio_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : gpio_conditioner
// Brief    : GPIO pin synchroniser + debouncer with edge pulses, rising-edge
//            counter and LED drive (level follow or retriggerable flash).
// Revision : 1.0
// ============================================================================
module gpio_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int STRETCH_CYCLES  = 1200000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        gpio_in,
  input  logic        led_mode,
  input  logic        clear_count,
  output logic        level_out,
  output logic        rise_pulse,
  output logic        fall_pulse,
  output logic [15:0] edge_count,
  output logic        led_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] C_STRETCH  = SW'(STRETCH_CYCLES);

  localparam logic [1:0] S_LOW    = 2'd0;
  localparam logic [1:0] S_WAIT_H = 2'd1;
  localparam logic [1:0] S_HIGH   = 2'd2;
  localparam logic [1:0] S_WAIT_L = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_q;
  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_pulse_q, rise_d;
  logic                   fall_pulse_q, fall_d;
  logic [15:0]            edge_count_q, edge_count_d;
  logic [SW-1:0]          scnt_q, scnt_d;
  logic                   led_q, led_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
    end
  end

  assign s_q = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      S_LOW: begin
        if (s_q) begin
          state_d = S_WAIT_H;
          cnt_d   = '0;
        end
      end
      S_WAIT_H: begin
        if (!s_q) begin
          state_d = S_LOW;
        end else if (cnt_q == C_CNT_LAST) begin
          state_d = S_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HIGH: begin
        if (!s_q) begin
          state_d = S_WAIT_L;
          cnt_d   = '0;
        end
      end
      S_WAIT_L: begin
        if (s_q) begin
          state_d = S_HIGH;
        end else if (cnt_q == C_CNT_LAST) begin
          state_d = S_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_LOW;
    endcase
  end

  // Clear wins over the old value but a coincident rise still counts.
  always_comb begin
    edge_count_d = edge_count_q;
    if (clear_count) begin
      edge_count_d = rise_pulse_q ? 16'd1 : 16'd0;
    end else if (rise_pulse_q) begin
      edge_count_d = edge_count_q + 16'd1;
    end
  end

  // Stretch counter loads alongside the pulse register so the flash starts
  // the cycle after the pulse and lasts exactly STRETCH_CYCLES cycles.
  always_comb begin
    scnt_d = scnt_q;
    if (rise_d || fall_d) begin
      scnt_d = C_STRETCH;
    end else if (scnt_q != '0) begin
      scnt_d = scnt_q - SW'(1);
    end
    led_d = led_mode ? (scnt_q != '0) : level_q;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_LOW;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
      edge_count_q <= '0;
      scnt_q       <= '0;
      led_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      rise_pulse_q <= rise_d;
      fall_pulse_q <= fall_d;
      edge_count_q <= edge_count_d;
      scnt_q       <= scnt_d;
      led_q        <= led_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_pulse_q;
  assign fall_pulse = fall_pulse_q;
  assign edge_count = edge_count_q;
  assign led_out    = led_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_conditioner
// Brief    : scoreboard bench for gpio_conditioner with a run-length model.
// Revision : 1.0
// ============================================================================
module tb_gpio_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int STR  = 8;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        gpio = 1'b0;
  logic        mode = 1'b0;
  logic        clr  = 1'b0;
  logic        level, rise, fall, led;
  logic [15:0] cnt;

  gpio_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .STRETCH_CYCLES (STR)
  ) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .gpio_in    (gpio),
    .led_mode   (mode),
    .clear_count(clr),
    .level_out  (level),
    .rise_pulse (rise),
    .fall_pulse (fall),
    .edge_count (cnt),
    .led_out    (led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        level;
    logic        rise;
    logic        fall;
    logic [15:0] count;
    logic        led;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_rise   = 0;
  bit   model_started = 0;

  // Reference model: the pin seen SYNC edges late; a value differing from
  // the committed level for DEB+1 consecutive edges commits.
  bit [SYNC-1:0] hist;
  int            run;
  bit            lvl;
  bit            m_rise, m_fall, m_led;
  logic [15:0]   m_cnt;
  int            age;

  always @(posedge clk) begin : model
    exp_t        e;
    bit          s_pre, nr, nf, nled;
    logic [15:0] ncnt;
    if (rst) begin
      hist = '0; run = 0; lvl = 0; m_rise = 0; m_fall = 0;
      m_cnt = '0; age = STR; m_led = 0;
    end else begin
      s_pre = hist[SYNC-1];
      nr = 0;
      nf = 0;
      nled = mode ? (age < STR) : lvl;
      if (clr) ncnt = m_rise ? 16'd1 : 16'd0;
      else     ncnt = m_rise ? m_cnt + 16'd1 : m_cnt;
      if (s_pre != lvl) begin
        run++;
        if (run == DEB + 1) begin
          lvl = s_pre;
          nr  = s_pre;
          nf  = !s_pre;
          run = 0;
        end
      end else begin
        run = 0;
      end
      if (nr || nf)     age = 0;
      else if (age < STR) age++;
      hist   = {hist[SYNC-2:0], gpio};
      m_rise = nr;
      m_fall = nf;
      m_cnt  = ncnt;
      m_led  = nled;
    end
    e = '{lvl, m_rise, m_fall, m_cnt, m_led};
    sb_q.push_back(e);
    model_started = 1;
  end

  always @(negedge clk) begin : monitor
    exp_t e, a;
    a = '{level, rise, fall, cnt, led};
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs t=%0t actual lvl=%b rise=%b fall=%b cnt=%h led=%b required lvl=%b rise=%b fall=%b cnt=%h led=%b",
                 $time, a.level, a.rise, a.fall, a.count, a.led,
                 e.level, e.rise, e.fall, e.count, e.led);
      end
      if (rise) n_rise++;
    end else if (model_started) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty t=%0t actual=none required=entry", $time);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic count_led(input int window, output int highs);
    highs = 0;
    for (int i = 0; i < window; i++) begin
      tick(1);
      if (led) highs++;
    end
  endtask

  initial begin : stim
    int n0, highs;
    int widths[3] = '{1, 3, 4};

    // Reset state
    tick(2);
    chk("reset_level", int'(level), 0);
    chk("reset_count", int'(cnt), 0);
    chk("reset_led",   int'(led), 0);
    rst = 1'b0;
    tick(3);

    // Rise latency
    gpio = 1'b1;
    tick(6);
    chk("lat_level_e6", int'(level), 0);
    tick(1);
    chk("lat_level_e7", int'(level), 1);
    chk("lat_rise_e7",  int'(rise), 1);
    chk("lat_cnt_e7",   int'(cnt), 0);
    chk("lat_led_e7",   int'(led), 0);
    tick(1);
    chk("lat_rise_e8",  int'(rise), 0);
    chk("lat_cnt_e8",   int'(cnt), 1);
    chk("lat_led_e8",   int'(led), 1);

    // Fall latency
    tick(5);
    gpio = 1'b0;
    tick(7);
    chk("fall_e7",     int'(fall), 1);
    chk("fall_level",  int'(level), 0);
    chk("fall_cnt",    int'(cnt), 1);
    tick(1);
    chk("fall_e8",     int'(fall), 0);

    // Glitch rejection
    tick(10);
    n0 = n_rise;
    foreach (widths[i]) begin
      gpio = 1'b1;
      tick(widths[i]);
      gpio = 1'b0;
      tick(6);
    end
    chk("glitch_no_rise", n_rise - n0, 0);
    chk("glitch_level",   int'(level), 0);
    gpio = 1'b1;
    tick(5);
    gpio = 1'b0;
    tick(8);
    chk("glitch5_one_rise", n_rise - n0, 1);
    tick(12);

    // Activity flash, single and retriggered
    mode = 1'b1;
    tick(12);
    gpio = 1'b1;
    count_led(20, highs);
    chk("flash_single", highs, STR);
    gpio = 1'b0;
    tick(20);
    gpio = 1'b1;
    tick(5);
    gpio = 1'b0;
    count_led(25, highs);
    chk("flash_retrigger", highs, 13);
    tick(5);

    // Counter wrap and clear
    mode = 1'b0;
    tick(10);
    force dut.edge_count_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    tick(1);
    release dut.edge_count_q;
    for (int k = 0; k < 2; k++) begin
      gpio = 1'b1;
      tick(5);
      gpio = 1'b0;
      tick(14);
    end
    chk("wrap_zero", int'(cnt), 0);
    gpio = 1'b1;
    tick(7);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clear_with_rise", int'(cnt), 1);
    gpio = 1'b0;
    tick(14);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clear_alone", int'(cnt), 0);

    // Asynchronous reset mid-debounce
    gpio = 1'b1;
    tick(5);
    gpio = 1'b0;
    tick(14);
    gpio = 1'b1;
    tick(5);
    rst = 1'b1;
    #1;
    chk("async_rst_cnt",   int'(cnt), 0);
    chk("async_rst_level", int'(level), 0);
    chk("async_rst_led",   int'(led), 0);
    tick(2);
    rst = 1'b0;
    n0 = n_rise;
    tick(6);
    chk("post_rst_e6", int'(level), 0);
    tick(1);
    chk("post_rst_rise", int'(rise), 1);
    tick(10);
    chk("post_rst_one_rise", n_rise - n0, 1);

    // Randomised traffic
    for (int s = 0; s < 250; s++) begin
      gpio = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) begin
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
      end
      tick($urandom_range(1, 9));
    end
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
